veri_onbellek_temizleyici: RTL and testbench
============================================

# veri_onbellek_temizleyici

Maintenance sequencer for the 2-way, 256-set data cache RAM group (tag/data way RAMs plus combined valid/dirty/LRU RAM). After reset it walks every set and invalidates it. On a flush request it walks every set, writes each valid+dirty word back over the iomem bus, then invalidates the set. While `mesgul_o` is high it owns the cache RAM ports and the iomem write channel; the cache controller muxes onto them otherwise.

## Interface
Parameters:
- `SET_SAYISI`, 256, number of sets; index width is 8.
- `TABAN_ADR`, 13'h0800, upper address bits [31:19] used for write-back addresses.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `temizle_istek_i` in 1: flush request; sampled only in BOSTA.
- `mesgul_o` out 1: walk in progress.
- `temizle_bitti_o` out 1: one-cycle pulse when a walk completes.
- `yol_A0_o` out 8: set index to the way RAMs and the combined RAM.
- `yol0_EN0_o`, `yol1_EN0_o` out 1: per-way write enable (tag byte + state bits).
- `yol_WE0_o` out 4: data byte write enables.
- `yol_Di0_o` out 41: write data, {tag[8:0], word[31:0]}.
- `yol0_Do0_i`, `yol1_Do0_i` in 41: asynchronous read data, valid in the same cycle as `yol_A0_o`.
- `yol0_valid_i`, `yol0_dirty_i`, `yol1_valid_i`, `yol1_dirty_i` in 1: asynchronous state-bit reads.
- `yol0_valid_o`, `yol0_dirty_o`, `yol1_valid_o`, `yol1_dirty_o`, `lru_o` out 1: state-bit write values.
- `iomem_valid_o` out 1, `iomem_ready_i` in 1, `iomem_wstrb_o` out 4, `iomem_addr_o` out 32, `iomem_wdata_o` out 32: write channel.

## Operation
- Registers: `durum` (state), `idx` (8 bits), `geri_yaz` (1 = flush walk, 0 = init walk), latched `tag0`/`tag1` (9 bits each), `veri0`/`veri1` (32 bits each), and per-way `kirli` flags.
- BOSTA:
  - `mesgul_o`=0.
  - `temizle_istek_i`=1 → `idx`=0, `geri_yaz`=1, go to KONTROL.
- KONTROL:
  - Drive `yol_A0_o`=`idx`, all EN=0.
  - Latch both ways' tag/data.
  - `kirli0` = `geri_yaz` & v0 & d0; `kirli1` = `geri_yaz` & v1 & d1.
  - Next state: `kirli0` → YAZ0, else `kirli1` → YAZ1, else TEMIZLE.
- YAZ0:
  - `iomem_valid_o`=1, `iomem_wstrb_o`=4'hF.
  - `iomem_addr_o` = {`TABAN_ADR`, `tag0`, `idx`, 2'b00}; `iomem_wdata_o` = `veri0`.
  - Hold all five until `iomem_ready_i`=1.
  - On the ready cycle: `kirli1` → YAZ1, else TEMIZLE.
- YAZ1: same as YAZ0 using `tag1`/`veri1`; on ready → TEMIZLE.
- TEMIZLE:
  - `yol_A0_o`=`idx`, `yol0_EN0_o`=`yol1_EN0_o`=1, `yol_WE0_o`=0.
  - `yol_Di0_o`=0; all valid/dirty/lru outputs 0.
  - If `idx`==`SET_SAYISI`-1 → BITTI; else `idx`+1 → KONTROL.
- BITTI: `temizle_bitti_o`=1 for this cycle only → BOSTA.
- Outside YAZ0/YAZ1: `iomem_valid_o`=0, `iomem_wstrb_o`=0. Addr/wdata may hold stale values.
- Outside TEMIZLE: both EN=0 and `yol_WE0_o`=0.

## Timing
- Reset:
  - An edge with `rst`=1 forces `durum`=KONTROL, `idx`=0, `geri_yaz`=0.
  - `mesgul_o`=1 from the following cycle; `iomem_valid_o`=0, `temizle_bitti_o`=0, EN=0.
  - While `rst` stays high, no RAM write occurs.
- Reset mid-walk: an in-flight iomem write is abandoned (`iomem_valid_o` low the cycle after the reset edge), and the init walk restarts at set 0.
- Init walk: 2 cycles per set. `temizle_bitti_o` fires 2·`SET_SAYISI` cycles after reset release (512 for the default).
- Flush walk: 2 cycles per set plus 1+W cycles per dirty word, where W is the iomem wait cycles before ready. Ready in the first YAZ cycle gives W=0.
- Handshake: a transfer completes on the edge where `iomem_valid_o`=`iomem_ready_i`=1. `iomem_valid_o` never drops before ready except on reset.
- `temizle_istek_i` while `mesgul_o`=1 is ignored, not queued.
- A request held high across BITTI starts a new flush two cycles after BITTI (BOSTA → KONTROL).
- `idx` does not wrap: the walk terminates at set `SET_SAYISI`-1.

## Test plan
- Reset with `rst`=1 for 3 cycles, then release → 512 TEMIZLE cycles covering sets 0..255 with EN=1, `iomem_valid_o` never high, `temizle_bitti_o` pulse at cycle 512.
- Flush with set 5 way0 valid+dirty (tag 9'h1A3, word 32'hDEADBEEF), `iomem_ready_i` tied 1 → exactly one write at address {13'h0800, 9'h1A3, 8'h05, 2'b00} with data DEADBEEF. Walk length 513 cycles.
- Flush with set 255 both ways dirty, ready delayed 3 cycles each → writes in order way0 then way1, addr/wdata stable during the wait, then TEMIZLE of set 255, then BITTI.
- Set 10 way1 valid but clean and set 11 way0 dirty but invalid → no write-back for either.
- Assert `rst` while YAZ0 waits for ready → `iomem_valid_o` low the next cycle, init walk restarts at `idx`=0 with no write-back.
- Pulse `temizle_istek_i` mid-walk → ignored; exactly one `temizle_bitti_o` pulse, then BOSTA.

Source files
------------

// File: rtl/veri_onbellek_temizleyici_if.sv
// Write channel toward iomem used by the cache maintenance sequencer.
// master drives the request side; slave answers with ready.
interface veri_onbellek_temizleyici_if;
    logic        iomem_valid_o;
    logic        iomem_ready_i;
    logic [3:0]  iomem_wstrb_o;
    logic [31:0] iomem_addr_o;
    logic [31:0] iomem_wdata_o;

    modport master (
        output iomem_valid_o,
        output iomem_wstrb_o,
        output iomem_addr_o,
        output iomem_wdata_o,
        input  iomem_ready_i
    );

    modport slave (
        input  iomem_valid_o,
        input  iomem_wstrb_o,
        input  iomem_addr_o,
        input  iomem_wdata_o,
        output iomem_ready_i
    );
endinterface

// File: rtl/veri_onbellek_temizleyici.sv
// Cache maintenance sequencer: invalidates every set after reset and, on request,
// writes back valid+dirty words before invalidating. Owns the cache RAM ports while busy.
module veri_onbellek_temizleyici #(
    parameter int unsigned SET_SAYISI = 256,
    parameter logic [12:0] TABAN_ADR  = 13'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        temizle_istek_i,
    output logic        mesgul_o,
    output logic        temizle_bitti_o,
    output logic [7:0]  yol_A0_o,
    output logic        yol0_EN0_o,
    output logic        yol1_EN0_o,
    output logic [3:0]  yol_WE0_o,
    output logic [40:0] yol_Di0_o,
    input  logic [40:0] yol0_Do0_i,
    input  logic [40:0] yol1_Do0_i,
    input  logic        yol0_valid_i,
    input  logic        yol0_dirty_i,
    input  logic        yol1_valid_i,
    input  logic        yol1_dirty_i,
    output logic        yol0_valid_o,
    output logic        yol0_dirty_o,
    output logic        yol1_valid_o,
    output logic        yol1_dirty_o,
    output logic        lru_o,
    veri_onbellek_temizleyici_if.master iomem
);

    localparam logic [7:0] SON_IDX = 8'(SET_SAYISI - 1);

    typedef enum logic [2:0] {
        BOSTA, KONTROL, YAZ0, YAZ1, TEMIZLE, BITTI
    } durum_t;

    durum_t      durum;
    logic [7:0]  idx;
    logic        geri_yaz;
    logic        kirli1;
    logic        yaz_en;
    logic [8:0]  tag1;
    logic [31:0] veri1;
    logic        kirli0_c;
    logic        kirli1_c;

    assign kirli0_c = geri_yaz & yol0_valid_i & yol0_dirty_i;
    assign kirli1_c = geri_yaz & yol1_valid_i & yol1_dirty_i;

    // Invalidation writes all-zero tag and state bits; data bytes are never touched.
    assign yol_A0_o     = idx;
    assign yol0_EN0_o   = yaz_en;
    assign yol1_EN0_o   = yaz_en;
    assign yol_WE0_o    = 4'h0;
    assign yol_Di0_o    = 41'd0;
    assign yol0_valid_o = 1'b0;
    assign yol0_dirty_o = 1'b0;
    assign yol1_valid_o = 1'b0;
    assign yol1_dirty_o = 1'b0;
    assign lru_o        = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            durum               <= KONTROL;
            idx                 <= 8'd0;
            geri_yaz            <= 1'b0;
            kirli1              <= 1'b0;
            yaz_en              <= 1'b0;
            mesgul_o            <= 1'b1;
            temizle_bitti_o     <= 1'b0;
            iomem.iomem_valid_o <= 1'b0;
            iomem.iomem_wstrb_o <= 4'h0;
        end else begin
            temizle_bitti_o <= 1'b0;
            case (durum)
                BOSTA: begin
                    if (temizle_istek_i) begin
                        idx      <= 8'd0;
                        geri_yaz <= 1'b1;
                        mesgul_o <= 1'b1;
                        durum    <= KONTROL;
                    end
                end
                KONTROL: begin
                    kirli1 <= kirli1_c;
                    if (kirli0_c || kirli1_c) begin
                        iomem.iomem_valid_o <= 1'b1;
                        iomem.iomem_wstrb_o <= 4'hF;
                        durum               <= kirli0_c ? YAZ0 : YAZ1;
                    end else begin
                        yaz_en <= 1'b1;
                        durum  <= TEMIZLE;
                    end
                end
                YAZ0: begin
                    if (iomem.iomem_ready_i) begin
                        if (kirli1) begin
                            durum <= YAZ1;
                        end else begin
                            iomem.iomem_valid_o <= 1'b0;
                            iomem.iomem_wstrb_o <= 4'h0;
                            yaz_en              <= 1'b1;
                            durum               <= TEMIZLE;
                        end
                    end
                end
                YAZ1: begin
                    if (iomem.iomem_ready_i) begin
                        iomem.iomem_valid_o <= 1'b0;
                        iomem.iomem_wstrb_o <= 4'h0;
                        yaz_en              <= 1'b1;
                        durum               <= TEMIZLE;
                    end
                end
                TEMIZLE: begin
                    yaz_en <= 1'b0;
                    if (idx == SON_IDX) begin
                        temizle_bitti_o <= 1'b1;
                        durum           <= BITTI;
                    end else begin
                        idx   <= idx + 8'd1;
                        durum <= KONTROL;
                    end
                end
                BITTI: begin
                    mesgul_o <= 1'b0;
                    durum    <= BOSTA;
                end
                default: begin
                    mesgul_o <= 1'b0;
                    yaz_en   <= 1'b0;
                    durum    <= BOSTA;
                end
            endcase
        end
    end

    // Write-back address/data: way0 is loaded from the RAM read in KONTROL, way1
    // from its latched copy once way0 has been accepted.
    always_ff @(posedge clk) begin
        if (durum == KONTROL) begin
            tag1  <= yol1_Do0_i[40:32];
            veri1 <= yol1_Do0_i[31:0];
            if (kirli0_c) begin
                iomem.iomem_addr_o  <= {TABAN_ADR, yol0_Do0_i[40:32], idx, 2'b00};
                iomem.iomem_wdata_o <= yol0_Do0_i[31:0];
            end else begin
                iomem.iomem_addr_o  <= {TABAN_ADR, yol1_Do0_i[40:32], idx, 2'b00};
                iomem.iomem_wdata_o <= yol1_Do0_i[31:0];
            end
        end else if (durum == YAZ0 && iomem.iomem_ready_i) begin
            iomem.iomem_addr_o  <= {TABAN_ADR, tag1, idx, 2'b00};
            iomem.iomem_wdata_o <= veri1;
        end
    end

endmodule

// File: tb/tb_veri_onbellek_temizleyici.sv
// Bench for the cache maintenance sequencer: behavioural way RAMs, an iomem
// responder with programmable wait, and a write-back scoreboard.
module tb_veri_onbellek_temizleyici;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        temizle_istek_i = 1'b0;
    logic        mesgul_o, temizle_bitti_o;
    logic [7:0]  yol_A0_o;
    logic        yol0_EN0_o, yol1_EN0_o;
    logic [3:0]  yol_WE0_o;
    logic [40:0] yol_Di0_o, yol0_Do0_i, yol1_Do0_i;
    logic        yol0_valid_i, yol0_dirty_i, yol1_valid_i, yol1_dirty_i;
    logic        yol0_valid_o, yol0_dirty_o, yol1_valid_o, yol1_dirty_o, lru_o;

    veri_onbellek_temizleyici_if bus ();

    veri_onbellek_temizleyici dut (
        .clk(clk), .rst(rst), .temizle_istek_i(temizle_istek_i),
        .mesgul_o(mesgul_o), .temizle_bitti_o(temizle_bitti_o),
        .yol_A0_o(yol_A0_o), .yol0_EN0_o(yol0_EN0_o), .yol1_EN0_o(yol1_EN0_o),
        .yol_WE0_o(yol_WE0_o), .yol_Di0_o(yol_Di0_o),
        .yol0_Do0_i(yol0_Do0_i), .yol1_Do0_i(yol1_Do0_i),
        .yol0_valid_i(yol0_valid_i), .yol0_dirty_i(yol0_dirty_i),
        .yol1_valid_i(yol1_valid_i), .yol1_dirty_i(yol1_dirty_i),
        .yol0_valid_o(yol0_valid_o), .yol0_dirty_o(yol0_dirty_o),
        .yol1_valid_o(yol1_valid_o), .yol1_dirty_o(yol1_dirty_o),
        .lru_o(lru_o), .iomem(bus.master)
    );

    always #5 clk = ~clk;

    logic [8:0]  m_tag0 [0:255];
    logic [8:0]  m_tag1 [0:255];
    logic [31:0] m_dat0 [0:255];
    logic [31:0] m_dat1 [0:255];
    logic        m_v0 [0:255];
    logic        m_d0 [0:255];
    logic        m_v1 [0:255];
    logic        m_d1 [0:255];

    assign yol0_Do0_i   = {m_tag0[yol_A0_o], m_dat0[yol_A0_o]};
    assign yol1_Do0_i   = {m_tag1[yol_A0_o], m_dat1[yol_A0_o]};
    assign yol0_valid_i = m_v0[yol_A0_o];
    assign yol0_dirty_i = m_d0[yol_A0_o];
    assign yol1_valid_i = m_v1[yol_A0_o];
    assign yol1_dirty_i = m_d1[yol_A0_o];

    int checks = 0;
    int errors = 0;

    int cyc, en_cnt, en_viol, rst_en_viol, vld_cnt, kararsiz, bitti_cnt, bitti_cyc;
    int son_en_idx, son_en_cyc;
    int rdelay = 0;
    int wcnt = 0;
    bit yazildi [0:255];
    bit mes_hist [0:2047];
    bit onceki_bekle = 1'b0;
    logic [63:0] onceki_aw;
    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];
    int          xfer_cyc [$];

    // iomem responder: ready after rdelay cycles of valid, per transfer
    always begin
        @(posedge clk);
        #1;
        if (bus.iomem_valid_o !== 1'b1) begin
            wcnt = 0;
            bus.iomem_ready_i = 1'b0;
        end else if (wcnt >= rdelay) begin
            bus.iomem_ready_i = 1'b1;
            wcnt = 0;
        end else begin
            bus.iomem_ready_i = 1'b0;
            wcnt++;
        end
    end

    // Monitor on the falling edge: RAM write model, transfer capture, pulse timing
    always @(negedge clk) begin
        if (rst && (yol0_EN0_o === 1'b1 || yol1_EN0_o === 1'b1)) rst_en_viol++;
        if (yol0_EN0_o === 1'b1 || yol1_EN0_o === 1'b1) begin
            if (!(yol0_EN0_o && yol1_EN0_o) || yol_WE0_o != 4'h0 || yol_Di0_o != 41'd0 ||
                {yol0_valid_o, yol0_dirty_o, yol1_valid_o, yol1_dirty_o, lru_o} != 5'd0)
                en_viol++;
            en_cnt++;
            yazildi[yol_A0_o] = 1'b1;
            son_en_idx = int'(yol_A0_o);
            son_en_cyc = cyc;
            m_v0[yol_A0_o] = 1'b0; m_d0[yol_A0_o] = 1'b0; m_tag0[yol_A0_o] = yol_Di0_o[40:32];
            m_v1[yol_A0_o] = 1'b0; m_d1[yol_A0_o] = 1'b0; m_tag1[yol_A0_o] = yol_Di0_o[40:32];
        end else if (yol_WE0_o === 4'hF) begin
            en_viol++;
        end
        if (bus.iomem_valid_o === 1'b1) begin
            vld_cnt++;
            if (bus.iomem_wstrb_o !== 4'hF) en_viol++;
            if (onceki_bekle && ({bus.iomem_addr_o, bus.iomem_wdata_o} !== onceki_aw)) kararsiz++;
            if (bus.iomem_ready_i === 1'b1) begin
                obs_q.push_back({bus.iomem_addr_o, bus.iomem_wdata_o});
                xfer_cyc.push_back(cyc);
                onceki_bekle = 1'b0;
            end else begin
                onceki_bekle = 1'b1;
                onceki_aw = {bus.iomem_addr_o, bus.iomem_wdata_o};
            end
        end else begin
            onceki_bekle = 1'b0;
            if (bus.iomem_wstrb_o === 4'hF) en_viol++;
        end
        if (temizle_bitti_o === 1'b1) begin
            bitti_cnt++;
            bitti_cyc = cyc;
        end
        if (cyc >= 0 && cyc < 2048) mes_hist[cyc] = (mesgul_o === 1'b1);
        cyc++;
    end

    task automatic sayac_sifirla();
        cyc = 0; en_cnt = 0; en_viol = 0; vld_cnt = 0; kararsiz = 0;
        bitti_cnt = 0; bitti_cyc = -1; son_en_idx = -1; son_en_cyc = -1;
        obs_q.delete(); xfer_cyc.delete();
        for (int i = 0; i < 256; i++) yazildi[i] = 1'b0;
        for (int i = 0; i < 2048; i++) mes_hist[i] = 1'b0;
    endtask

    task automatic bekle_bitti(input int limit, output bit ok);
        int bas;
        bas = bitti_cnt;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #2;
            if (bitti_cnt != bas) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic baslat_temizle();
        @(posedge clk); #2;
        temizle_istek_i = 1'b1;
        @(posedge clk); #2;
        temizle_istek_i = 1'b0;
        sayac_sifirla();
    endtask

    task automatic test_reset();
        bit ok;
        int n;
        rst = 1'b1;
        @(posedge clk); #2;
        checks++; if (mesgul_o !== 1'b1) begin errors++; $display("FAIL rst_mesgul: got %b want 1", mesgul_o); end
        checks++; if (bus.iomem_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.iomem_valid_o); end
        checks++; if (temizle_bitti_o !== 1'b0) begin errors++; $display("FAIL rst_bitti: got %b want 0", temizle_bitti_o); end
        checks++; if ({yol0_EN0_o, yol1_EN0_o} !== 2'b00) begin errors++; $display("FAIL rst_en: got %b want 00", {yol0_EN0_o, yol1_EN0_o}); end
        checks++; if (yol_A0_o !== 8'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", yol_A0_o); end
        @(posedge clk); @(posedge clk); #2;
        checks++; if (rst_en_viol !== 0) begin errors++; $display("FAIL rst_no_write: got %0d want 0", rst_en_viol); end
        rst = 1'b0;
        sayac_sifirla();
        bekle_bitti(700, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_timeout: got %b want 1", ok); end
        checks++; if (bitti_cyc !== 512) begin errors++; $display("FAIL init_len: got %0d want 512", bitti_cyc); end
        checks++; if (en_cnt !== 256) begin errors++; $display("FAIL init_en_cnt: got %0d want 256", en_cnt); end
        n = 0;
        for (int i = 0; i < 256; i++) if (yazildi[i]) n++;
        checks++; if (n !== 256) begin errors++; $display("FAIL init_sets: got %0d want 256", n); end
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL init_no_iomem: got %0d want 0", vld_cnt); end
        checks++; if (en_viol !== 0) begin errors++; $display("FAIL init_write_fmt: got %0d want 0", en_viol); end
        checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL init_idle: got %b want 0", mesgul_o); end
        checks++; if (temizle_bitti_o !== 1'b0) begin errors++; $display("FAIL init_pulse_len: got %b want 0", temizle_bitti_o); end
    endtask

    task automatic test_tek_yazma();
        bit ok;
        logic [31:0] adr;
        logic [63:0] e, o;
        adr = {13'h0800, 9'h1A3, 8'h05, 2'b00};
        m_v0[5] = 1'b1; m_d0[5] = 1'b1; m_tag0[5] = 9'h1A3; m_dat0[5] = 32'hDEADBEEF;
        exp_q.push_back({adr, 32'hDEADBEEF});
        rdelay = 0;
        baslat_temizle();
        bekle_bitti(800, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tek_timeout: got %b want 1", ok); end
        checks++; if (bitti_cyc !== 513) begin errors++; $display("FAIL tek_len: got %0d want 513", bitti_cyc); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL tek_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL tek_write: got %h want %h", o, e); end
        end
        exp_q.delete();
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL tek_valid_cycles: got %0d want 1", vld_cnt); end
        checks++; if (m_v0[5] !== 1'b0) begin errors++; $display("FAIL tek_invalidated: got %b want 0", m_v0[5]); end
        checks++; if (en_viol !== 0) begin errors++; $display("FAIL tek_fmt: got %0d want 0", en_viol); end
    endtask

    task automatic test_cift_bekleme();
        bit ok;
        logic [63:0] e, o;
        m_v0[255] = 1'b1; m_d0[255] = 1'b1; m_tag0[255] = 9'h0F0; m_dat0[255] = 32'h12345678;
        m_v1[255] = 1'b1; m_d1[255] = 1'b1; m_tag1[255] = 9'h10F; m_dat1[255] = 32'hA5A5A5A5;
        exp_q.push_back({13'h0800, 9'h0F0, 8'hFF, 2'b00, 32'h12345678});
        exp_q.push_back({13'h0800, 9'h10F, 8'hFF, 2'b00, 32'hA5A5A5A5});
        rdelay = 3;
        baslat_temizle();
        bekle_bitti(800, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cift_timeout: got %b want 1", ok); end
        checks++; if (bitti_cyc !== 520) begin errors++; $display("FAIL cift_len: got %0d want 520", bitti_cyc); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL cift_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL cift_write: got %h want %h", o, e); end
        end
        exp_q.delete();
        if (xfer_cyc.size() == 2) begin
            checks++; if (xfer_cyc[0] !== 514) begin errors++; $display("FAIL cift_xfer0_cyc: got %0d want 514", xfer_cyc[0]); end
            checks++; if (xfer_cyc[1] !== 518) begin errors++; $display("FAIL cift_xfer1_cyc: got %0d want 518", xfer_cyc[1]); end
        end
        checks++; if (kararsiz !== 0) begin errors++; $display("FAIL cift_stable: got %0d want 0", kararsiz); end
        checks++; if (vld_cnt !== 8) begin errors++; $display("FAIL cift_valid_cycles: got %0d want 8", vld_cnt); end
        checks++; if (son_en_idx !== 255) begin errors++; $display("FAIL cift_last_set: got %0d want 255", son_en_idx); end
        checks++; if (son_en_cyc !== 519) begin errors++; $display("FAIL cift_last_clear_cyc: got %0d want 519", son_en_cyc); end
        rdelay = 0;
    endtask

    task automatic test_temiz_gecersiz();
        bit ok;
        m_v1[10] = 1'b1; m_d1[10] = 1'b0; m_tag1[10] = 9'h033; m_dat1[10] = 32'h0BADF00D;
        m_v0[11] = 1'b0; m_d0[11] = 1'b1; m_tag0[11] = 9'h044; m_dat0[11] = 32'h600DCAFE;
        rdelay = 0;
        baslat_temizle();
        bekle_bitti(800, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tg_timeout: got %b want 1", ok); end
        checks++; if (bitti_cyc !== 512) begin errors++; $display("FAIL tg_len: got %0d want 512", bitti_cyc); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL tg_no_write: got %0d want 0", obs_q.size()); end
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL tg_no_valid: got %0d want 0", vld_cnt); end
        checks++; if (m_v1[10] !== 1'b0) begin errors++; $display("FAIL tg_set10_clear: got %b want 0", m_v1[10]); end
        checks++; if (m_d0[11] !== 1'b0) begin errors++; $display("FAIL tg_set11_clear: got %b want 0", m_d0[11]); end
    endtask

    task automatic test_reset_yazma();
        bit ok;
        bit goruldu;
        m_v0[100] = 1'b1; m_d0[100] = 1'b1; m_tag0[100] = 9'h055; m_dat0[100] = 32'hCAFEF00D;
        rdelay = 100000;
        baslat_temizle();
        goruldu = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #2;
            if (bus.iomem_valid_o === 1'b1) begin
                goruldu = 1'b1;
                break;
            end
        end
        checks++; if (goruldu !== 1'b1) begin errors++; $display("FAIL ry_wait_valid: got %b want 1", goruldu); end
        checks++; if (yol_A0_o !== 8'd100) begin errors++; $display("FAIL ry_set: got %0d want 100", yol_A0_o); end
        rst = 1'b1;
        @(posedge clk); #2;
        checks++; if (bus.iomem_valid_o !== 1'b0) begin errors++; $display("FAIL ry_abandon: got %b want 0", bus.iomem_valid_o); end
        checks++; if (mesgul_o !== 1'b1) begin errors++; $display("FAIL ry_mesgul: got %b want 1", mesgul_o); end
        checks++; if (yol_A0_o !== 8'd0) begin errors++; $display("FAIL ry_idx: got %0d want 0", yol_A0_o); end
        rst = 1'b0;
        sayac_sifirla();
        rdelay = 0;
        bekle_bitti(800, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ry_timeout: got %b want 1", ok); end
        checks++; if (bitti_cyc !== 512) begin errors++; $display("FAIL ry_len: got %0d want 512", bitti_cyc); end
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL ry_no_writeback: got %0d want 0", vld_cnt); end
        checks++; if (m_v0[100] !== 1'b0) begin errors++; $display("FAIL ry_invalidated: got %b want 0", m_v0[100]); end
    endtask

    task automatic test_istek_yoksay();
        bit ok;
        rdelay = 0;
        baslat_temizle();
        repeat (100) @(posedge clk);
        #2;
        temizle_istek_i = 1'b1;
        @(posedge clk); #2;
        temizle_istek_i = 1'b0;
        bekle_bitti(800, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL yok_timeout: got %b want 1", ok); end
        checks++; if (bitti_cyc !== 512) begin errors++; $display("FAIL yok_len: got %0d want 512", bitti_cyc); end
        repeat (10) @(posedge clk);
        #2;
        checks++; if (bitti_cnt !== 1) begin errors++; $display("FAIL yok_pulses: got %0d want 1", bitti_cnt); end
        checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL yok_idle: got %b want 0", mesgul_o); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        rdelay = 0;
        @(posedge clk); #2;
        temizle_istek_i = 1'b1;
        @(posedge clk); #2;
        sayac_sifirla();
        bekle_bitti(800, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout1: got %b want 1", ok); end
        checks++; if (bitti_cyc !== 512) begin errors++; $display("FAIL b2b_len: got %0d want 512", bitti_cyc); end
        repeat (2) @(posedge clk);
        #2;
        temizle_istek_i = 1'b0;
        checks++; if (mes_hist[513] !== 1'b0) begin errors++; $display("FAIL b2b_idle_cycle: got %b want 0", mes_hist[513]); end
        checks++; if (mes_hist[514] !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", mes_hist[514]); end
        bekle_bitti(800, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout2: got %b want 1", ok); end
        checks++; if (bitti_cnt !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", bitti_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_tag0[i] = 9'(i); m_tag1[i] = 9'(i + 7);
            m_dat0[i] = 32'(i * 3); m_dat1[i] = 32'(i * 5);
            m_v0[i] = 1'b1; m_d0[i] = 1'b1; m_v1[i] = 1'b1; m_d1[i] = 1'b1;
        end
        sayac_sifirla();
        rst_en_viol = 0;
        test_reset();
        test_tek_yazma();
        test_cift_bekleme();
        test_temiz_gecersiz();
        test_reset_yazma();
        test_istek_yoksay();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
